spi_flash_arbiter: RTL and testbench
====================================

// Module: spi_flash_arbiter
// PURPOSE
// - Clocked owner of the shared SPI flash bus between the FT2232 programming port and the 6809-side SPI master.
// - Sequences every handover: halt CPU, drain CPU transfer, grant FT, then release with a timed CPU reset.
// - Sits between both SPI masters and the flash pins. Drives o_HALT/o_RESET to the 6809 glue.
// PARAMETERS
// - SYNC_STAGES   2      flops in the i_FT_CS synchroniser
// - HALT_SETTLE   16     clocks after CPU idle before FT grant
// - DRAIN_TIMEOUT 4096   max clocks waiting for CPU SPI idle before forced grant
// - IDLE_RELEASE  65536  clocks of continuous FT CS high that ends an FT session
// - RESET_CYCLES  64     clocks o_RESET held after FT session ends
// PORTS
// - i_clk          in   1  system clock
// - i_rst_n        in   1  asynchronous active-low reset
// - i_FT_CS        in   1  FT2232 chip select, active low, asynchronous to i_clk
// - i_FT_SCK       in   1  FT2232 SPI clock
// - i_FT_MOSI      in   1  FT2232 data out
// - o_FT_MISO      out  1  flash data returned to FT2232
// - i_CPU_SPI_CS   in   1  6809 SPI master chip select, active low
// - i_CPU_SPI_CLK  in   1  6809 SPI master clock
// - i_CPU_SPI_MOSI in   1  6809 SPI master data out
// - i_cpu_spi_busy in   1  6809 SPI master mid-transfer
// - o_CPU_SPI_MISO out  1  flash data returned to 6809 master
// - i_SPI_MISO     in   1  flash data out
// - o_SPI_CS       out  1  flash chip select
// - o_SPI_CLK      out  1  flash clock
// - o_SPI_MOSI     out  1  flash data in
// - o_HALT         out  1  6809 halt request, active high
// - o_RESET        out  1  6809 reset request, active high
// - o_ft_owner     out  1  FT currently owns flash bus
// - o_drain_to     out  1  sticky: last grant was forced by DRAIN_TIMEOUT
// BEHAVIOUR
// - Reset: state CPU_OWN. o_HALT=0, o_RESET=0, o_ft_owner=0, o_drain_to=0, all counters 0.
// - Reset also presets the synchroniser to 1 (CS inactive).
// - i_FT_CS passes through SYNC_STAGES flops to give ft_cs_s. No other FT signal is synchronised.
// - States and transitions:
//   - CPU_OWN: ft_cs_s==0 -> HALT_REQ.
//   - HALT_REQ: o_HALT=1. Clear counter -> DRAIN next cycle.
//   - DRAIN: if !i_cpu_spi_busy && i_CPU_SPI_CS==1, count to HALT_SETTLE, then -> FT_OWN.
//     - Either condition dropping restarts the settle count.
//     - A separate count reaching DRAIN_TIMEOUT forces -> FT_OWN and sets o_drain_to.
//   - FT_OWN: o_ft_owner=1, o_HALT=1. ft_cs_s==1 counts; any ft_cs_s==0 clears the count.
//     - Count reaching IDLE_RELEASE -> RESET_CPU.
//   - RESET_CPU: o_HALT=1, o_RESET=1 for RESET_CYCLES clocks -> CPU_OWN.
//     - ft_cs_s==0 during RESET_CPU does not abort; it is serviced from CPU_OWN afterwards.
// - o_drain_to clears on the next successful non-forced grant or on reset.
// - Latency: i_FT_CS fall to o_HALT=1 is SYNC_STAGES+1 clocks.
// - FT host contract: after first CS assertion, wait >= (SYNC_STAGES+2+HALT_SETTLE) clocks before the first SCK edge.
//   - Worst case is DRAIN_TIMEOUT.
// - Bus mux: combinational from registered state, so no clock-domain latency on SPI data.
//   - FT_OWN: o_SPI_CS/CLK/MOSI = i_FT_CS/SCK/MOSI. o_FT_MISO=i_SPI_MISO. o_CPU_SPI_MISO=1.
//   - CPU_OWN: o_SPI_* = CPU inputs. o_CPU_SPI_MISO=i_SPI_MISO. o_FT_MISO=1.
//   - HALT_REQ/DRAIN/RESET_CPU: o_SPI_CS=1, o_SPI_CLK=0, o_SPI_MOSI=0. Both MISO outputs are 1.
// - No tri-state outputs. Pad-level tri-stating belongs to the top level.
// - Counter width: $clog2 of the largest of HALT_SETTLE, DRAIN_TIMEOUT, IDLE_RELEASE, RESET_CYCLES, plus 1. Saturates, never wraps.
// - Asynchronous reset mid-session: bus returns to CPU immediately. o_HALT/o_RESET drop. The external CPU reset covers recovery.
// STRUCTURE
// - spi_arb_defs.vh: state encodings (CPU_OWN, HALT_REQ, DRAIN, FT_OWN, RESET_CPU) and idle-bus constant values.
// - Sub-module cdc_sync_n: SYNC_STAGES-deep synchroniser, async reset, reset value 1.
// - Everything else (FSM, single shared counter, drain counter, mux) lives in this module.
// TESTING
// - FT CS low with CPU idle -> o_HALT high at clock 3. o_ft_owner high at clock 3+1+16. Flash pins follow FT.
// - FT CS low while i_cpu_spi_busy=1 for 100 clks -> grant 16 clks after busy drops. o_drain_to stays 0.
// - FT CS low with busy stuck 1 -> grant at DRAIN_TIMEOUT. o_drain_to=1 until next clean grant.
// - FT session of 3 CS pulses with 1000-clk gaps -> stays FT_OWN.
//   - 65536 idle clocks later -> o_RESET high for 64 clocks, then o_HALT=o_RESET=0 and CPU owns.
// - FT CS low during RESET_CPU -> reset completes 64 clocks, then a new HALT_REQ begins.
// - i_rst_n asserted in FT_OWN -> same cycle: o_ft_owner=0, o_HALT=0, flash pins follow CPU inputs.

Source files
------------

// File: rtl/spi_flash_arbiter_pkg.sv
// Shared types and constants for the SPI flash bus arbiter.
package spi_flash_arbiter_pkg;

    typedef enum logic [2:0] {
        CPU_OWN   = 3'd0,
        HALT_REQ  = 3'd1,
        DRAIN     = 3'd2,
        FT_OWN    = 3'd3,
        RESET_CPU = 3'd4
    } arb_state_e;

    typedef struct packed {
        logic cs;
        logic clk;
        logic mosi;
    } spi_bus_t;

    // Flash pins while nobody owns the bus: deselected, clock low.
    localparam spi_bus_t SPI_BUS_IDLE = '{cs: 1'b1, clk: 1'b0, mosi: 1'b0};
    localparam logic     MISO_IDLE    = 1'b1;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_flash_arbiter_cdc_sync_n.sv
// N-deep flop synchroniser with asynchronous reset to a fixed value.
module spi_flash_arbiter_cdc_sync_n #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/spi_flash_arbiter.sv
// Owns the shared SPI flash bus; hands it between the 6809 SPI master and the
// FT2232 port, halting the CPU during FT sessions and resetting it afterwards.
module spi_flash_arbiter
    import spi_flash_arbiter_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned HALT_SETTLE   = 16,
    parameter int unsigned DRAIN_TIMEOUT = 4096,
    parameter int unsigned IDLE_RELEASE  = 65536,
    parameter int unsigned RESET_CYCLES  = 64
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_FT_CS,
    input  logic i_FT_SCK,
    input  logic i_FT_MOSI,
    output logic o_FT_MISO,
    input  logic i_CPU_SPI_CS,
    input  logic i_CPU_SPI_CLK,
    input  logic i_CPU_SPI_MOSI,
    input  logic i_cpu_spi_busy,
    output logic o_CPU_SPI_MISO,
    input  logic i_SPI_MISO,
    output logic o_SPI_CS,
    output logic o_SPI_CLK,
    output logic o_SPI_MOSI,
    output logic o_HALT,
    output logic o_RESET,
    output logic o_ft_owner,
    output logic o_drain_to
);

    localparam int unsigned CW = $clog2(max_u(max_u(HALT_SETTLE, DRAIN_TIMEOUT),
                                              max_u(IDLE_RELEASE, RESET_CYCLES))) + 1;

    localparam logic [CW-1:0] SETTLE_LAST = CW'(HALT_SETTLE - 1);
    localparam logic [CW-1:0] DRAIN_LAST  = CW'(DRAIN_TIMEOUT - 1);
    localparam logic [CW-1:0] IDLE_LAST   = CW'(IDLE_RELEASE - 1);
    localparam logic [CW-1:0] RESET_LAST  = CW'(RESET_CYCLES - 1);

    arb_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] dcnt_q, dcnt_d;
    logic          drain_to_q, drain_to_d;
    logic          halt_q, reset_q, owner_q;
    logic          ft_cs_s;
    logic          cpu_idle;
    spi_bus_t      cpu_bus, ft_bus, bus_c;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == '1) ? v : v + CW'(1);
    endfunction

    spi_flash_arbiter_cdc_sync_n #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_ft_cs_sync (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .d     (i_FT_CS),
        .q     (ft_cs_s)
    );

    assign cpu_idle = !i_cpu_spi_busy && i_CPU_SPI_CS;

    // Next-state: cnt_q is shared by settle, FT idle and CPU reset timing.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dcnt_d     = dcnt_q;
        drain_to_d = drain_to_q;
        case (state_q)
            CPU_OWN: begin
                cnt_d  = '0;
                dcnt_d = '0;
                if (!ft_cs_s) state_d = HALT_REQ;
            end
            HALT_REQ: begin
                cnt_d   = '0;
                dcnt_d  = '0;
                state_d = DRAIN;
            end
            DRAIN: begin
                dcnt_d = sat_inc(dcnt_q);
                cnt_d  = cpu_idle ? sat_inc(cnt_q) : '0;
                if (cpu_idle && cnt_q == SETTLE_LAST) begin
                    state_d    = FT_OWN;
                    cnt_d      = '0;
                    drain_to_d = 1'b0;
                end else if (dcnt_q == DRAIN_LAST) begin
                    state_d    = FT_OWN;
                    cnt_d      = '0;
                    drain_to_d = 1'b1;
                end
            end
            FT_OWN: begin
                if (!ft_cs_s) begin
                    cnt_d = '0;
                end else if (cnt_q == IDLE_LAST) begin
                    state_d = RESET_CPU;
                    cnt_d   = '0;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            RESET_CPU: begin
                if (cnt_q == RESET_LAST) begin
                    state_d = CPU_OWN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            default: begin
                state_d = CPU_OWN;
                cnt_d   = '0;
                dcnt_d  = '0;
            end
        endcase
    end

    // State and registered CPU-control outputs, decoded from the next state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= CPU_OWN;
            cnt_q      <= '0;
            dcnt_q     <= '0;
            drain_to_q <= 1'b0;
            halt_q     <= 1'b0;
            reset_q    <= 1'b0;
            owner_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dcnt_q     <= dcnt_d;
            drain_to_q <= drain_to_d;
            halt_q     <= (state_d != CPU_OWN);
            reset_q    <= (state_d == RESET_CPU);
            owner_q    <= (state_d == FT_OWN);
        end
    end

    assign o_HALT     = halt_q;
    assign o_RESET    = reset_q;
    assign o_ft_owner = owner_q;
    assign o_drain_to = drain_to_q;

    assign cpu_bus = '{cs: i_CPU_SPI_CS, clk: i_CPU_SPI_CLK, mosi: i_CPU_SPI_MOSI};
    assign ft_bus  = '{cs: i_FT_CS,      clk: i_FT_SCK,      mosi: i_FT_MOSI};

    // Pin mux decoded from registered state only, so SPI data sees no clock latency.
    always_comb begin
        bus_c          = SPI_BUS_IDLE;
        o_FT_MISO      = MISO_IDLE;
        o_CPU_SPI_MISO = MISO_IDLE;
        case (state_q)
            FT_OWN: begin
                bus_c     = ft_bus;
                o_FT_MISO = i_SPI_MISO;
            end
            CPU_OWN: begin
                bus_c          = cpu_bus;
                o_CPU_SPI_MISO = i_SPI_MISO;
            end
            default: ;
        endcase
    end

    assign o_SPI_CS   = bus_c.cs;
    assign o_SPI_CLK  = bus_c.clk;
    assign o_SPI_MOSI = bus_c.mosi;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Directed-plus-random bench for spi_flash_arbiter; expected timing is derived
// arithmetically from the handover rules.
module tb_spi_flash_arbiter;

    localparam int unsigned SYNC_STAGES   = 2;
    localparam int unsigned HALT_SETTLE   = 16;
    localparam int unsigned DRAIN_TIMEOUT = 4096;
    localparam int unsigned IDLE_RELEASE  = 1024;
    localparam int unsigned RESET_CYCLES  = 64;

    localparam int T_HALT = SYNC_STAGES + 1;
    localparam int R_EDGE = IDLE_RELEASE + SYNC_STAGES;
    localparam int MODE_CPU  = 0;
    localparam int MODE_FT   = 1;
    localparam int MODE_IDLE = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic ft_cs = 1'b1, ft_sck = 1'b0, ft_mosi = 1'b0;
    logic cpu_cs = 1'b1, cpu_clk = 1'b0, cpu_mosi = 1'b0, cpu_busy = 1'b0;
    logic spi_miso = 1'b1;
    logic o_ft_miso, o_cpu_miso, o_spi_cs, o_spi_clk, o_spi_mosi;
    logic o_halt, o_reset, o_owner, o_dto;

    int n_checks = 0;
    int n_pass   = 0;
    bit exp_dto  = 1'b0;

    spi_flash_arbiter #(
        .SYNC_STAGES   (SYNC_STAGES),
        .HALT_SETTLE   (HALT_SETTLE),
        .DRAIN_TIMEOUT (DRAIN_TIMEOUT),
        .IDLE_RELEASE  (IDLE_RELEASE),
        .RESET_CYCLES  (RESET_CYCLES)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_FT_CS        (ft_cs),
        .i_FT_SCK       (ft_sck),
        .i_FT_MOSI      (ft_mosi),
        .o_FT_MISO      (o_ft_miso),
        .i_CPU_SPI_CS   (cpu_cs),
        .i_CPU_SPI_CLK  (cpu_clk),
        .i_CPU_SPI_MOSI (cpu_mosi),
        .i_cpu_spi_busy (cpu_busy),
        .o_CPU_SPI_MISO (o_cpu_miso),
        .i_SPI_MISO     (spi_miso),
        .o_SPI_CS       (o_spi_cs),
        .o_SPI_CLK      (o_spi_clk),
        .o_SPI_MOSI     (o_spi_mosi),
        .o_HALT         (o_halt),
        .o_RESET        (o_reset),
        .o_ft_owner     (o_owner),
        .o_drain_to     (o_dto)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] expv);
        n_checks++;
        assert (obs === expv) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic chk_ctrl(input string tag, input logic h, input logic r,
                            input logic o, input logic d);
        chk({tag, "_ctrl"}, {1'b0, o_halt, o_reset, o_owner, o_dto}, {1'b0, h, r, o, d});
    endtask

    task automatic chk_bus(input string tag, input int mode);
        logic [4:0] e;
        case (mode)
            MODE_FT:  e = {ft_cs, ft_sck, ft_mosi, spi_miso, 1'b1};
            MODE_CPU: e = {cpu_cs, cpu_clk, cpu_mosi, 1'b1, spi_miso};
            default:  e = 5'b10011;
        endcase
        chk({tag, "_bus"}, {o_spi_cs, o_spi_clk, o_spi_mosi, o_ft_miso, o_cpu_miso}, e);
    endtask

    task automatic rand_pins(input bit cpu_ctl);
        ft_sck   = 1'($urandom);
        ft_mosi  = 1'($urandom);
        cpu_clk  = 1'($urandom);
        cpu_mosi = 1'($urandom);
        spi_miso = 1'($urandom);
        if (cpu_ctl) begin
            cpu_cs   = 1'($urandom);
            cpu_busy = 1'($urandom);
        end
    endtask

    // FT CS falls from CPU_OWN; grant edge = 16th consecutive idle DRAIN edge, else timeout.
    task automatic session_grant(input string tag, input int nb, input int gl, input bit stuck);
        int  last_bad, s, g, f;
        bit  forced;
        last_bad = (gl > 0) ? nb + gl : nb;
        s = (T_HALT + 2 > last_bad + 1) ? T_HALT + 2 : last_bad + 1;
        g = s + int'(HALT_SETTLE) - 1;
        f = T_HALT + 1 + int'(DRAIN_TIMEOUT);
        forced = stuck || (g > f);
        if (forced) g = f;
        for (int k = 1; k <= g; k++) begin
            ft_cs    = 1'b0;
            cpu_busy = stuck || (k <= nb);
            cpu_cs   = !(gl > 0 && k == nb + gl);
            rand_pins(1'b0);
            @(negedge clk);
            if (k == T_HALT - 1) chk_ctrl({tag, "_prehalt"}, 1'b0, 1'b0, 1'b0, exp_dto);
            if (k == T_HALT) begin
                chk_ctrl({tag, "_halt"}, 1'b1, 1'b0, 1'b0, exp_dto);
                chk_bus({tag, "_halt"}, MODE_IDLE);
            end
            if (k == g - 1) chk_ctrl({tag, "_pregrant"}, 1'b1, 1'b0, 1'b0, exp_dto);
            if (k == g) begin
                chk_ctrl({tag, "_grant"}, 1'b1, 1'b0, 1'b1, forced);
                chk_bus({tag, "_grant"}, MODE_FT);
            end
        end
        exp_dto  = forced;
        cpu_busy = 1'b0;
        cpu_cs   = 1'b1;
    endtask

    // FT CS rises in FT_OWN; optionally re-asserted cs_low_at edges into the CPU reset.
    task automatic release_session(input string tag, input int cs_low_at);
        int rh, rg, last;
        rh   = R_EDGE + int'(RESET_CYCLES) + 1;
        rg   = rh + int'(HALT_SETTLE) + 1;
        last = (cs_low_at > 0) ? rg : R_EDGE + int'(RESET_CYCLES);
        for (int k = 1; k <= last; k++) begin
            if (k == 1) ft_cs = 1'b1;
            if (cs_low_at > 0 && k == R_EDGE + cs_low_at) ft_cs = 1'b0;
            cpu_busy = 1'b0;
            cpu_cs   = 1'b1;
            rand_pins(1'b0);
            @(negedge clk);
            if (k == R_EDGE - 1) chk_ctrl({tag, "_prerel"}, 1'b1, 1'b0, 1'b1, exp_dto);
            if (k == R_EDGE) begin
                chk_ctrl({tag, "_rst_on"}, 1'b1, 1'b1, 1'b0, exp_dto);
                chk_bus({tag, "_rst_on"}, MODE_IDLE);
            end
            if (k == R_EDGE + int'(RESET_CYCLES) - 1)
                chk_ctrl({tag, "_rst_last"}, 1'b1, 1'b1, 1'b0, exp_dto);
            if (k == R_EDGE + int'(RESET_CYCLES)) begin
                chk_ctrl({tag, "_cpu_back"}, 1'b0, 1'b0, 1'b0, exp_dto);
                chk_bus({tag, "_cpu_back"}, MODE_CPU);
            end
            if (cs_low_at > 0 && k == rh) chk_ctrl({tag, "_rehalt"}, 1'b1, 1'b0, 1'b0, exp_dto);
            if (cs_low_at > 0 && k == rg - 1) chk_ctrl({tag, "_pregrant"}, 1'b1, 1'b0, 1'b0, exp_dto);
            if (cs_low_at > 0 && k == rg) begin
                chk_ctrl({tag, "_regrant"}, 1'b1, 1'b0, 1'b1, 1'b0);
                exp_dto = 1'b0;
            end
        end
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk);
        rand_pins(1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk_ctrl(tag, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_bus(tag, MODE_CPU);
        ft_cs    = 1'b1;
        cpu_cs   = 1'b1;
        cpu_busy = 1'b0;
        exp_dto  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk_ctrl("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            rand_pins(1'b1);
            #1;
            chk_bus("reset", MODE_CPU);
        end
        cpu_cs   = 1'b1;
        cpu_busy = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk_ctrl("post_reset", 1'b0, 1'b0, 1'b0, 1'b0);
        chk_bus("post_reset", MODE_CPU);

        session_grant("idle", 0, 0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            rand_pins(1'b1);
            #1;
            chk_bus("ft_pass", MODE_FT);
            @(negedge clk);
        end
        cpu_cs   = 1'b1;
        cpu_busy = 1'b0;

        for (int p = 0; p < 3; p++) begin
            ft_cs = 1'b1;
            repeat ($urandom_range(900, 1000)) @(negedge clk);
            chk_ctrl("gap", 1'b1, 1'b0, 1'b1, exp_dto);
            ft_cs = 1'b0;
            repeat ($urandom_range(3, 10)) @(negedge clk);
            chk_bus("pulse", MODE_FT);
        end
        release_session("rel_cs", 10);

        async_reset("arst_ft");

        session_grant("busy", int'($urandom_range(80, 120)), int'($urandom_range(3, 8)), 1'b0);
        async_reset("arst_busy");

        session_grant("stuck", 0, 0, 1'b1);
        release_session("rel_stuck", 0);
        session_grant("clean", 0, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
